// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception flag layout, NaN-box constant and the
// writeback entry record used between the f64->f32 converter and the FP register file.
package fpu_pkg;

  localparam int FLAGS_W  = 5;
  localparam int FLAG_NX  = 0;
  localparam int FLAG_UF  = 1;
  localparam int FLAG_OF  = 2;
  localparam int FLAG_DZ  = 3;
  localparam int FLAG_NV  = 4;
  localparam int WB_TAG_W = 5;

  localparam logic [31:0] NANBOX_F32 = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0]         data;
    logic [FLAGS_W-1:0]  flags;
    logic [WB_TAG_W-1:0] tag;
  } wb_entry_t;

  // Widen an f32 to the 64-bit FP register format; upper half all ones when boxing.
  function automatic logic [63:0] nanbox_f32(input logic [31:0] value, input logic box_en);
    return {(box_en ? NANBOX_F32 : 32'h0), value};
  endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic in-order synchronous FIFO with flush and occupancy count.
// The head entry is read combinationally from registered storage.
module fpu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_enq,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_deq,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_enq;
  logic             w_deq;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_enq   = i_enq && !o_full && !i_flush && !reset;
  assign w_deq   = i_deq && !o_empty && !i_flush && !reset;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + AW'(1);
      if (w_deq) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Storage is deliberately left unreset; only valid entries are ever observed.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (w_enq && (r_wptr == AW'(gi))) r_mem[gi] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fpu_cvt_writeback.sv
// Writeback stage behind the f64->f32 converter: buffers results, drains them
// NaN-boxed to the FP register file and accumulates retired exception flags.
module fpu_cvt_writeback
  import fpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int NANBOX = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [31:0]              io_in_bits_data,
  input  logic [FLAGS_W-1:0]       io_in_bits_flags,
  input  logic [TAG_W-1:0]         io_in_bits_tag,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [63:0]              io_out_bits_data,
  output logic [TAG_W-1:0]         io_out_bits_tag,
  input  logic                     io_flush,
  input  logic                     io_fflags_wen,
  input  logic [FLAGS_W-1:0]       io_fflags_wdata,
  output logic [FLAGS_W-1:0]       io_fflags,
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = 32 + FLAGS_W + TAG_W;

  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [CW-1:0]      w_count;
  logic               w_empty;
  logic               w_full;
  logic               w_enq;
  logic               w_deq;
  logic [31:0]        w_head_data;
  logic [FLAGS_W-1:0] w_head_flags;
  logic [TAG_W-1:0]   w_head_tag;
  logic [FLAGS_W-1:0] w_retire_flags;
  logic [FLAGS_W-1:0] w_fflags_next;
  logic [FLAGS_W-1:0] r_fflags;

  // No full-bypass: a full FIFO refuses input even while it is draining.
  assign io_in_ready  = !reset && !w_full && !io_flush;
  assign io_out_valid = !reset && !w_empty && !io_flush;
  assign w_enq        = io_in_valid && io_in_ready;
  assign w_deq        = io_out_valid && io_out_ready;

  assign w_wr_entry = {io_in_bits_data, io_in_bits_flags, io_in_bits_tag};

  fpu_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_flush (io_flush),
    .i_enq   (w_enq),
    .i_wdata (w_wr_entry),
    .i_deq   (w_deq),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_head_data  = w_head[ENTRY_W-1 -: 32];
  assign w_head_flags = w_head[TAG_W +: FLAGS_W];
  assign w_head_tag   = w_head[TAG_W-1:0];

  assign io_out_bits_data = w_empty ? 64'h0 : nanbox_f32(w_head_data, NANBOX != 0);
  assign io_out_bits_tag  = w_empty ? '0 : w_head_tag;
  assign io_count         = w_count;

  // Only retiring entries contribute; a CSR write replaces the old value but
  // must not drop the flags of a result retiring in the same cycle.
  assign w_retire_flags = w_deq ? w_head_flags : '0;

  always_comb begin
    w_fflags_next = r_fflags;
    if (io_fflags_wen) w_fflags_next = io_fflags_wdata | w_retire_flags;
    else               w_fflags_next = r_fflags | w_retire_flags;
  end

  always_ff @(posedge clock) begin
    if (reset) r_fflags <= '0;
    else       r_fflags <= w_fflags_next;
  end

  assign io_fflags = r_fflags;

endmodule

// File: tb/tb_fpu_cvt_writeback.sv
// Self-checking bench for fpu_cvt_writeback: directed cycle table, full/backpressure
// sequence, randomized traffic against a queue model, and a post-reset wrap run.
module tb_fpu_cvt_writeback;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_bits_data;
  logic [4:0]  io_in_bits_flags;
  logic [4:0]  io_in_bits_tag;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_out_bits_data;
  logic [4:0]  io_out_bits_tag;
  logic        io_flush;
  logic        io_fflags_wen;
  logic [4:0]  io_fflags_wdata;
  logic [4:0]  io_fflags;
  logic [2:0]  io_count;

  always #5 clock = ~clock;

  fpu_cvt_writeback #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NANBOX(1)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_in_valid      (io_in_valid),
    .io_in_ready      (io_in_ready),
    .io_in_bits_data  (io_in_bits_data),
    .io_in_bits_flags (io_in_bits_flags),
    .io_in_bits_tag   (io_in_bits_tag),
    .io_out_valid     (io_out_valid),
    .io_out_ready     (io_out_ready),
    .io_out_bits_data (io_out_bits_data),
    .io_out_bits_tag  (io_out_bits_tag),
    .io_flush         (io_flush),
    .io_fflags_wen    (io_fflags_wen),
    .io_fflags_wdata  (io_fflags_wdata),
    .io_fflags        (io_fflags),
    .io_count         (io_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [31:0] d,
                       input logic [4:0] f, input logic [4:0] t, input logic ordy,
                       input logic fl, input logic wen, input logic [4:0] wd);
    reset            = rst;
    io_in_valid      = iv;
    io_in_bits_data  = d;
    io_in_bits_flags = f;
    io_in_bits_tag   = t;
    io_out_ready     = ordy;
    io_flush         = fl;
    io_fflags_wen    = wen;
    io_fflags_wdata  = wd;
  endtask

  // Directed cycle table: inputs for one cycle plus outputs expected in that cycle.
  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [31:0] d;
    logic [4:0]  f;
    logic [4:0]  t;
    logic        ordy;
    logic        fl;
    logic        wen;
    logic [4:0]  wd;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_d;
    logic [4:0]  e_t;
    logic [2:0]  e_c;
    logic [4:0]  e_ff;
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic iv, input logic [31:0] d,
                               input logic [4:0] f, input logic [4:0] t, input logic ordy,
                               input logic fl, input logic wen, input logic [4:0] wd,
                               input logic e_ir, input logic e_ov, input logic [63:0] e_d,
                               input logic [4:0] e_t, input logic [2:0] e_c, input logic [4:0] e_ff);
    vec_t v;
    v = '{rst, iv, d, f, t, ordy, fl, wen, wd, e_ir, e_ov, e_d, e_t, e_c, e_ff};
    return v;
  endfunction

  vec_t tbl [21];

  // Reference model: an ordered list of accepted results and the sticky flag word.
  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  f;
    logic [4:0]  t;
  } ent_t;

  ent_t       mq [$];
  logic [4:0] m_ff;

  task automatic mstep(input string nm);
    logic        e_ir, e_ov, deq, enq;
    logic [63:0] e_d;
    logic [4:0]  e_t, ret;
    e_ir = !reset && (mq.size() < DEPTH) && !io_flush;
    e_ov = !reset && (mq.size() != 0) && !io_flush;
    e_d  = (mq.size() != 0) ? {32'hFFFF_FFFF, mq[0].d} : 64'h0;
    e_t  = (mq.size() != 0) ? mq[0].t : 5'h0;
    #1;
    check({nm, ".in_ready"},  io_in_ready,      e_ir);
    check({nm, ".out_valid"}, io_out_valid,     e_ov);
    check({nm, ".data"},      io_out_bits_data, e_d);
    check({nm, ".tag"},       io_out_bits_tag,  e_t);
    check({nm, ".count"},     io_count,         mq.size());
    check({nm, ".fflags"},    io_fflags,        m_ff);
    if (reset) begin
      mq.delete();
      m_ff = 5'h0;
    end else begin
      deq = e_ov && io_out_ready;
      enq = e_ir && io_in_valid;
      ret = deq ? mq[0].f : 5'h0;
      m_ff = io_fflags_wen ? (io_fflags_wdata | ret) : (m_ff | ret);
      if (io_flush) mq.delete();
      else begin
        if (deq) void'(mq.pop_front());
        if (enq) mq.push_back('{io_in_bits_data, io_in_bits_flags, io_in_bits_tag});
      end
    end
    @(posedge clock);
  endtask

  localparam logic [63:0] BOX = 64'hFFFF_FFFF_0000_0000;

  initial begin
    int         next_tag, acc_cycle, n_drained, n_xfer;
    logic [4:0] drained [$];

    tbl[0]  = mkv(0,1,32'h3F800000,5'h01,5'd3, 1,0,0,5'h00, 1,0,64'h0,             5'd0, 3'd0,5'h00);
    tbl[1]  = mkv(0,0,32'h0,       5'h00,5'd0, 1,0,0,5'h00, 1,1,BOX|64'h3F800000, 5'd3, 3'd1,5'h00);
    tbl[2]  = mkv(0,0,32'h0,       5'h00,5'd0, 1,0,0,5'h00, 1,0,64'h0,             5'd0, 3'd0,5'h01);
    tbl[3]  = mkv(0,1,32'h40000000,5'h04,5'd6, 0,0,1,5'h00, 1,0,64'h0,             5'd0, 3'd0,5'h01);
    tbl[4]  = mkv(0,1,32'h40400000,5'h01,5'd7, 1,0,0,5'h00, 1,1,BOX|64'h40000000, 5'd6, 3'd1,5'h00);
    tbl[5]  = mkv(0,1,32'h40800000,5'h00,5'd8, 1,0,0,5'h00, 1,1,BOX|64'h40400000, 5'd7, 3'd1,5'h04);
    tbl[6]  = mkv(0,0,32'h0,       5'h00,5'd0, 1,0,0,5'h00, 1,1,BOX|64'h40800000, 5'd8, 3'd1,5'h05);
    tbl[7]  = mkv(0,0,32'h0,       5'h00,5'd0, 1,0,0,5'h00, 1,0,64'h0,             5'd0, 3'd0,5'h05);
    tbl[8]  = mkv(0,0,32'h0,       5'h00,5'd0, 1,0,0,5'h00, 1,0,64'h0,             5'd0, 3'd0,5'h05);
    tbl[9]  = mkv(0,1,32'h3F000000,5'h02,5'd9, 0,0,1,5'h1F, 1,0,64'h0,             5'd0, 3'd0,5'h05);
    tbl[10] = mkv(0,0,32'h0,       5'h00,5'd0, 1,0,1,5'h00, 1,1,BOX|64'h3F000000, 5'd9, 3'd1,5'h1F);
    tbl[11] = mkv(0,0,32'h0,       5'h00,5'd0, 1,0,0,5'h00, 1,0,64'h0,             5'd0, 3'd0,5'h02);
    tbl[12] = mkv(0,1,32'h11111111,5'h10,5'd10,0,0,1,5'h00, 1,0,64'h0,             5'd0, 3'd0,5'h02);
    tbl[13] = mkv(0,1,32'h22222222,5'h10,5'd11,0,0,0,5'h00, 1,1,BOX|64'h11111111, 5'd10,3'd1,5'h00);
    tbl[14] = mkv(0,1,32'h33333333,5'h10,5'd12,0,0,0,5'h00, 1,1,BOX|64'h11111111, 5'd10,3'd2,5'h00);
    tbl[15] = mkv(0,1,32'h44444444,5'h1F,5'd13,1,1,0,5'h00, 0,0,BOX|64'h11111111, 5'd10,3'd3,5'h00);
    tbl[16] = mkv(0,0,32'h0,       5'h00,5'd0, 1,0,0,5'h00, 1,0,64'h0,             5'd0, 3'd0,5'h00);
    tbl[17] = mkv(0,1,32'h55555555,5'h1F,5'd14,0,0,1,5'h08, 1,0,64'h0,             5'd0, 3'd0,5'h00);
    tbl[18] = mkv(0,1,32'h66666666,5'h1F,5'd15,0,0,0,5'h00, 1,1,BOX|64'h55555555, 5'd14,3'd1,5'h08);
    tbl[19] = mkv(1,1,32'h77777777,5'h01,5'd16,1,0,1,5'h1F, 0,0,BOX|64'h55555555, 5'd14,3'd2,5'h08);
    tbl[20] = mkv(0,0,32'h0,       5'h00,5'd0, 1,0,0,5'h00, 1,0,64'h0,             5'd0, 3'd0,5'h00);

    // Reset: the first cycle settles the registers, the second is checked.
    @(negedge clock);
    drive(1, 0, 32'h0, 5'h0, 5'h0, 0, 0, 0, 5'h0);
    @(posedge clock);
    mq.delete();
    m_ff = 5'h0;
    @(negedge clock);
    mstep("reset");

    for (int i = 0; i < 21; i++) begin
      @(negedge clock);
      drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].f, tbl[i].t, tbl[i].ordy,
            tbl[i].fl, tbl[i].wen, tbl[i].wd);
      #1;
      check($sformatf("row%0d.in_ready", i),  io_in_ready,      tbl[i].e_ir);
      check($sformatf("row%0d.out_valid", i), io_out_valid,     tbl[i].e_ov);
      check($sformatf("row%0d.data", i),      io_out_bits_data, tbl[i].e_d);
      check($sformatf("row%0d.tag", i),       io_out_bits_tag,  tbl[i].e_t);
      check($sformatf("row%0d.count", i),     io_count,         tbl[i].e_c);
      check($sformatf("row%0d.fflags", i),    io_fflags,        tbl[i].e_ff);
      @(posedge clock);
    end

    // Full/backpressure: tags 1..5 offered with the sink stalled for six cycles.
    mq.delete();
    m_ff      = 5'h0;
    next_tag  = 1;
    acc_cycle = -1;
    drained.delete();
    for (int c = 0; c < 40 && drained.size() < 5; c++) begin
      @(negedge clock);
      drive(0, next_tag <= 5, 32'h1000 + 32'(next_tag), 5'h0, 5'(next_tag), c >= 6, 0, 0, 5'h0);
      #1;
      if (c == 5) begin
        check("full.count", io_count, 3'd4);
        check("full.in_ready", io_in_ready, 1'b0);
      end
      if (io_out_valid && io_out_ready) drained.push_back(io_out_bits_tag);
      if (io_in_valid && io_in_ready) begin
        if (next_tag == 5) acc_cycle = c;
        next_tag++;
      end
      mstep($sformatf("full.c%0d", c));
    end
    check("full.tag5_accept_cycle", 64'(acc_cycle), 64'd7);
    check("full.drained", 64'(drained.size()), 64'd5);
    for (int k = 0; k < drained.size(); k++)
      check($sformatf("full.order%0d", k), drained[k], 5'(k + 1));

    // Randomized traffic with occasional flush, CSR writes and resets.
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)));
      mstep($sformatf("rand.c%0d", c));
    end

    // Fresh reset then continuous streaming: pointers must wrap twice cleanly.
    @(negedge clock);
    drive(1, 0, 32'h0, 5'h0, 5'h0, 0, 0, 0, 5'h0);
    mstep("wrap.reset");
    n_xfer = 0;
    for (int c = 0; c < 2 * DEPTH + 2; c++) begin
      @(negedge clock);
      drive(0, 1, $urandom, 5'(1 << (c % 5)), 5'(c + 1), 1, 0, 0, 5'h0);
      #1;
      if (io_out_valid && io_out_ready) n_xfer++;
      mstep($sformatf("wrap.c%0d", c));
    end
    n_drained = n_xfer;
    check("wrap.transfers", 64'(n_drained), 64'(2 * DEPTH + 1));

    drive(0, 0, 32'h0, 5'h0, 5'h0, 0, 0, 0, 5'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
